writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
// Writeback stage feeding the decode-stage register file's single write port. Queues results from
// three producers (MEM, MUL, ALU) and arbitrates one register write per cycle. Exports a pending-
// write mask to decode for RAW/WAW hazard checks. Writes to index 0 are discarded (x0 stays zero).
// PARAMETERS
// WORD_SIZE     32               data width
// NUM_REGS      32               architectural registers incl. x0
// INDEX_WIDTH   $clog2(NUM_REGS) register index width
// QUEUE_DEPTH   2                entries per source queue; power of two, >=2
// STARVE_LIMIT  4                consecutive skipped cycles before a source is forced to the front
// PORTS
// clk              in   1            clock
// reset            in   1            synchronous, active-high
// {mem,mul,alu}_valid  in  1        per-source write request
// {mem,mul,alu}_ready  out 1        per-source accept; transfer on valid&&ready at rising edge
// {mem,mul,alu}_idx    in  INDEX_WIDTH  destination register
// {mem,mul,alu}_data   in  WORD_SIZE    result value
// rf_write_enable  out  1            register file write enable (registered)
// rf_write_idx     out  INDEX_WIDTH  register file write index (registered)
// rf_write_data    out  WORD_SIZE    register file write data (registered)
// pending_mask     out  NUM_REGS     bit i = a write to reg i is queued or on rf_write_*; bit 0 always 0
// busy             out  1            any queue non-empty or rf_write_enable high
// BEHAVIOUR
// - Reset: synchronous, active-high, on clk. Clears all queues, starvation counters, output regs. Sets
//   rf_write_enable=0, rf_write_idx=0, rf_write_data=0. pending_mask=0 and busy=0 from the next cycle.
//   Reset mid-operation drops queued entries; none reach rf_write_*.
// - x_ready = !reset && !queue_x_full. Depends only on state, never on x_valid. A pop in the same
//   cycle does not free a slot for a same-cycle accept.
// - Accept with idx==0: handshake completes, entry discarded, not enqueued.
// - Per-source FIFO order preserved. No reordering within a source. Cross-source ordering to the same
//   register is upstream's responsibility via pending_mask.
// - Selection, combinational each cycle over non-empty queue heads:
//   1. Any source with starve_cnt >= STARVE_LIMIT wins, MEM>MUL>ALU among those.
//   2. Otherwise fixed priority MEM>MUL>ALU.
// - Selected head is popped at the edge and loaded into the rf_write_* regs, rf_write_enable=1.
//   With no selection, rf_write_enable=0; idx/data hold their last value.
// - starve_cnt per source, saturating at STARVE_LIMIT:
//   +1 when non-empty and not selected; cleared when selected or empty.
// - Latency: accept at edge t -> rf_write_enable high during the cycle after edge t+1 (2 cycles min).
//   Sustained throughput: 1 write/cycle. A single source streaming at full rate never deasserts ready.
// - pending_mask: OR of decoded idx of every valid queue entry plus the rf_write_idx output reg when
//   rf_write_enable=1.
// TESTING
// 1. ALU idx5 data 0xDEADBEEF valid cycle0 -> rf_write_enable=1, idx5, 0xDEADBEEF in cycle2 only;
//    pending_mask[5]=1 cycles 1-2, 0 from cycle3.
// 2. MEM idx3, MUL idx4, ALU idx7 all valid in cycle0 -> rf writes idx3, idx4, idx7 in cycles 2, 3, 4;
//    busy=0 from cycle5.
// 3. ALU idx0 data 0xFFFFFFFF valid -> alu_ready=1, handshake completes; rf_write_enable never
//    asserts; pending_mask stays 0.
// 4. MEM and ALU valid every cycle from cycle0 (distinct idx):
//    - alu_ready=0 from cycle2;
//    - ALU head written in cycle6, after 4 skipped cycles (1-4) and forced selection in cycle5;
//    - MEM writes resume in cycle7.
// 5. Queue 2 entries each on MEM/MUL/ALU, assert reset for 1 cycle ->
//    - rf_write_enable=0 next cycle;
//    - pending_mask=0, all ready=1 after reset;
//    - no queued entry is ever written.
// 6. 8 back-to-back ALU writes idx1..8 -> 8 consecutive rf write cycles (2..9) in order;
//    alu_ready stays 1 throughout.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Queues MEM/MUL/ALU results and arbitrates them onto the single register file write port.
// Accept-to-write latency is 2 cycles; a source's ready drops only when its own queue is full.
module writeback_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int NUM_REGS     = 32,
    parameter int INDEX_WIDTH  = $clog2(NUM_REGS),
    parameter int QUEUE_DEPTH  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [INDEX_WIDTH-1:0] mem_idx,
    input  logic [WORD_SIZE-1:0]   mem_data,
    input  logic                   mul_valid,
    output logic                   mul_ready,
    input  logic [INDEX_WIDTH-1:0] mul_idx,
    input  logic [WORD_SIZE-1:0]   mul_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [INDEX_WIDTH-1:0] alu_idx,
    input  logic [WORD_SIZE-1:0]   alu_data,
    output logic                   rf_write_enable,
    output logic [INDEX_WIDTH-1:0] rf_write_idx,
    output logic [WORD_SIZE-1:0]   rf_write_data,
    output logic [NUM_REGS-1:0]    pending_mask,
    output logic                   busy
);
    localparam int NSRC  = 3;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // Source index 0 is MEM, 1 is MUL, 2 is ALU; lower index wins ties.
    logic [NSRC-1:0]        in_vld;
    logic [INDEX_WIDTH-1:0] in_idx [NSRC];
    logic [WORD_SIZE-1:0]   in_dat [NSRC];

    logic [INDEX_WIDTH-1:0] ent_idx_q [NSRC][QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0] ent_idx_d [NSRC][QUEUE_DEPTH];
    logic [WORD_SIZE-1:0]   ent_dat_q [NSRC][QUEUE_DEPTH];
    logic [WORD_SIZE-1:0]   ent_dat_d [NSRC][QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q [NSRC];
    logic [PTR_W-1:0]       wr_ptr_d [NSRC];
    logic [PTR_W-1:0]       rd_ptr_q [NSRC];
    logic [PTR_W-1:0]       rd_ptr_d [NSRC];
    logic [CNT_W-1:0]       cnt_q [NSRC];
    logic [CNT_W-1:0]       cnt_d [NSRC];
    logic [STV_W-1:0]       starve_q [NSRC];
    logic [STV_W-1:0]       starve_d [NSRC];
    logic                   rf_en_q, rf_en_d;
    logic [INDEX_WIDTH-1:0] rf_idx_q, rf_idx_d;
    logic [WORD_SIZE-1:0]   rf_dat_q, rf_dat_d;

    logic [NSRC-1:0]        rdy;
    logic [NSRC-1:0]        push;
    logic [NSRC-1:0]        pop;
    logic                   sel_vld;
    logic [1:0]             sel_src;
    logic [NUM_REGS-1:0]    pend;

    assign in_vld    = {alu_valid, mul_valid, mem_valid};
    assign in_idx[0] = mem_idx;
    assign in_idx[1] = mul_idx;
    assign in_idx[2] = alu_idx;
    assign in_dat[0] = mem_data;
    assign in_dat[1] = mul_data;
    assign in_dat[2] = alu_data;

    always_ff @(posedge clk) begin
        ent_idx_q <= ent_idx_d;
        ent_dat_q <= ent_dat_d;
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        cnt_q     <= cnt_d;
        starve_q  <= starve_d;
        rf_en_q   <= rf_en_d;
        rf_idx_q  <= rf_idx_d;
        rf_dat_q  <= rf_dat_d;
    end

    always_comb begin
        ent_idx_d = ent_idx_q;
        ent_dat_d = ent_dat_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        rf_en_d   = 1'b0;
        rf_idx_d  = rf_idx_q;
        rf_dat_d  = rf_dat_q;
        sel_vld   = 1'b0;
        sel_src   = 2'd0;
        rdy       = '0;
        push      = '0;
        pop       = '0;

        // Ready is state-only: a same-cycle pop never frees a slot for this cycle's accept.
        for (int s = 0; s < NSRC; s++)
            rdy[s] = !reset && (cnt_q[s] != CNT_W'(QUEUE_DEPTH));

        for (int s = 0; s < NSRC; s++)
            if (!sel_vld && cnt_q[s] != '0 && starve_q[s] >= STV_W'(STARVE_LIMIT)) begin
                sel_vld = 1'b1;
                sel_src = 2'(s);
            end
        for (int s = 0; s < NSRC; s++)
            if (!sel_vld && cnt_q[s] != '0) begin
                sel_vld = 1'b1;
                sel_src = 2'(s);
            end

        for (int s = 0; s < NSRC; s++) begin
            push[s] = in_vld[s] && rdy[s] && (in_idx[s] != '0);
            pop[s]  = sel_vld && (sel_src == 2'(s));
            if (push[s]) begin
                ent_idx_d[s][wr_ptr_q[s]] = in_idx[s];
                ent_dat_d[s][wr_ptr_q[s]] = in_dat[s];
                wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
            end
            if (pop[s])
                rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
            cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            if (cnt_q[s] == '0 || pop[s])
                starve_d[s] = '0;
            else if (starve_q[s] < STV_W'(STARVE_LIMIT))
                starve_d[s] = starve_q[s] + STV_W'(1);
        end

        if (sel_vld) begin
            rf_en_d  = 1'b1;
            rf_idx_d = ent_idx_q[sel_src][rd_ptr_q[sel_src]];
            rf_dat_d = ent_dat_q[sel_src][rd_ptr_q[sel_src]];
        end

        if (reset) begin
            for (int s = 0; s < NSRC; s++) begin
                for (int e = 0; e < QUEUE_DEPTH; e++) begin
                    ent_idx_d[s][e] = '0;
                    ent_dat_d[s][e] = '0;
                end
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
                cnt_d[s]    = '0;
                starve_d[s] = '0;
            end
            rf_en_d  = 1'b0;
            rf_idx_d = '0;
            rf_dat_d = '0;
        end
    end

    // Only the cnt_q oldest slots starting at the read pointer hold live entries.
    always_comb begin
        pend = '0;
        for (int s = 0; s < NSRC; s++)
            for (int k = 0; k < QUEUE_DEPTH; k++)
                if (k < int'(cnt_q[s]))
                    pend[ent_idx_q[s][rd_ptr_q[s] + PTR_W'(k)]] = 1'b1;
        if (rf_en_q)
            pend[rf_idx_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign mem_ready       = rdy[0];
    assign mul_ready       = rdy[1];
    assign alu_ready       = rdy[2];
    assign rf_write_enable = rf_en_q;
    assign rf_write_idx    = rf_idx_q;
    assign rf_write_data   = rf_dat_q;
    assign pending_mask    = pend;
    assign busy            = rf_en_q || (cnt_q[0] != '0) || (cnt_q[1] != '0) || (cnt_q[2] != '0);

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mul_valid, alu_valid;
    logic        mem_ready, mul_ready, alu_ready;
    logic [4:0]  mem_idx, mul_idx, alu_idx;
    logic [31:0] mem_data, mul_data, alu_data;
    logic        rf_write_enable;
    logic [4:0]  rf_write_idx;
    logic [31:0] rf_write_data;
    logic [31:0] pending_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    writeback_arbiter dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_idx(mem_idx), .mem_data(mem_data),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_idx(mul_idx), .mul_data(mul_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_idx(alu_idx), .alu_data(alu_data),
        .rf_write_enable(rf_write_enable), .rf_write_idx(rf_write_idx),
        .rf_write_data(rf_write_data), .pending_mask(pending_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mul_valid = 1'b0; alu_valid = 1'b0;
        mem_idx = '0; mul_idx = '0; alu_idx = '0;
        mem_data = '0; mul_data = '0; alu_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({mem_ready, mul_ready, alu_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_low: got %b expected 000", {mem_ready, mul_ready, alu_ready});
        end
        checks++;
        if ({rf_write_enable, rf_write_idx, rf_write_data, pending_mask, busy} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b idx=%0d data=%h mask=%h busy=%b expected all 0",
                     rf_write_enable, rf_write_idx, rf_write_data, pending_mask, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_ready, mul_ready, alu_ready} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_ready: got %b expected 111", {mem_ready, mul_ready, alu_ready});
        end
    endtask

    task automatic test_single_write();
        alu_valid = 1'b1; alu_idx = 5'd5; alu_data = 32'hDEADBEEF;
        checks++;
        if ({alu_ready, rf_write_enable, pending_mask} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL single_c0: ready=%b en=%b mask=%h expected 1 0 0", alu_ready, rf_write_enable, pending_mask);
        end
        step();
        idle_inputs();
        checks++;
        if ({rf_write_enable, pending_mask, busy} !== {1'b0, 32'h20, 1'b1}) begin
            errors++;
            $display("FAIL single_c1: en=%b mask=%h busy=%b expected 0 00000020 1", rf_write_enable, pending_mask, busy);
        end
        step();
        checks++;
        if ({rf_write_enable, rf_write_idx, rf_write_data, pending_mask} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h20}) begin
            errors++;
            $display("FAIL single_c2: en=%b idx=%0d data=%h mask=%h expected 1 5 deadbeef 00000020",
                     rf_write_enable, rf_write_idx, rf_write_data, pending_mask);
        end
        step();
        checks++;
        if ({rf_write_enable, rf_write_idx, rf_write_data, pending_mask, busy} !== {1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL single_c3_hold: en=%b idx=%0d data=%h mask=%h busy=%b expected 0 5 deadbeef 0 0",
                     rf_write_enable, rf_write_idx, rf_write_data, pending_mask, busy);
        end
    endtask

    task automatic test_fixed_priority();
        logic [4:0]  exp_idx [3] = '{5'd3, 5'd4, 5'd7};
        logic [31:0] exp_msk [3] = '{32'h98, 32'h90, 32'h80};
        mem_valid = 1'b1; mem_idx = 5'd3; mem_data = 32'h1111_0003;
        mul_valid = 1'b1; mul_idx = 5'd4; mul_data = 32'h2222_0004;
        alu_valid = 1'b1; alu_idx = 5'd7; alu_data = 32'h3333_0007;
        step();
        idle_inputs();
        step();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({rf_write_enable, rf_write_idx, pending_mask} !== {1'b1, exp_idx[c], exp_msk[c]}) begin
                errors++;
                $display("FAIL prio_c%0d: en=%b idx=%0d mask=%h expected 1 %0d %h",
                         c + 2, rf_write_enable, rf_write_idx, pending_mask, exp_idx[c], exp_msk[c]);
            end
            step();
        end
        checks++;
        if ({rf_write_enable, busy} !== 2'b00) begin
            errors++;
            $display("FAIL prio_c5_idle: en=%b busy=%b expected 0 0", rf_write_enable, busy);
        end
    endtask

    task automatic test_x0_discard();
        alu_valid = 1'b1; alu_idx = 5'd0; alu_data = 32'hFFFFFFFF;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b expected 1", alu_ready);
        end
        step();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({rf_write_enable, pending_mask, busy} !== 34'd0) begin
                errors++;
                $display("FAIL x0_c%0d: en=%b mask=%h busy=%b expected 0 0 0", c, rf_write_enable, pending_mask, busy);
            end
            step();
        end
    endtask

    task automatic test_starvation();
        logic       exp_en   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] exp_idx  [8] = '{5'd0, 5'd0, 5'd8, 5'd9, 5'd10, 5'd11, 5'd20, 5'd12};
        logic       exp_ardy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int n;
        for (int k = 0; k < 8; k++) begin
            mem_valid = 1'b1; mem_idx = 5'(8 + k);  mem_data = 32'hA000_0000 + 32'(8 + k);
            alu_valid = 1'b1; alu_idx = 5'(20 + k); alu_data = 32'hC000_0000 + 32'(20 + k);
            if (k < 7) begin
                checks++;
                if (alu_ready !== exp_ardy[k]) begin
                    errors++;
                    $display("FAIL starve_ready_c%0d: got %b expected %b", k, alu_ready, exp_ardy[k]);
                end
            end
            if (exp_en[k]) begin
                checks++;
                if ({rf_write_enable, rf_write_idx} !== {1'b1, exp_idx[k]}) begin
                    errors++;
                    $display("FAIL starve_write_c%0d: en=%b idx=%0d expected 1 %0d", k, rf_write_enable, rf_write_idx, exp_idx[k]);
                end
            end
            step();
        end
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL starve_drain: busy=%b after %0d cycles expected 0", busy, n);
        end
    endtask

    task automatic test_reset_flush();
        mem_valid = 1'b1; mem_idx = 5'd11; mem_data = 32'h11;
        mul_valid = 1'b1; mul_idx = 5'd12; mul_data = 32'h12;
        alu_valid = 1'b1; alu_idx = 5'd13; alu_data = 32'h13;
        step();
        mem_idx = 5'd14; mul_idx = 5'd15; alu_idx = 5'd16;
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_ready, mul_ready, alu_ready} !== 3'b000) begin
            errors++;
            $display("FAIL flush_ready_in_reset: got %b expected 000", {mem_ready, mul_ready, alu_ready});
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({rf_write_enable, pending_mask, busy, mem_ready, mul_ready, alu_ready} !== {1'b0, 32'h0, 1'b0, 3'b111}) begin
            errors++;
            $display("FAIL flush_after: en=%b mask=%h busy=%b ready=%b expected 0 0 0 111",
                     rf_write_enable, pending_mask, busy, {mem_ready, mul_ready, alu_ready});
        end
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (rf_write_enable !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_write_c%0d: en=%b idx=%0d expected en 0", c, rf_write_enable, rf_write_idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) begin
                alu_valid = 1'b1; alu_idx = 5'(k + 1); alu_data = 32'h100 + 32'(k + 1);
                checks++;
                if (alu_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_c%0d: got %b expected 1", k, alu_ready);
                end
            end else begin
                idle_inputs();
            end
            if (k >= 2 && k <= 9) begin
                checks++;
                if ({rf_write_enable, rf_write_idx, rf_write_data} !== {1'b1, 5'(k - 1), 32'h100 + 32'(k - 1)}) begin
                    errors++;
                    $display("FAIL b2b_write_c%0d: en=%b idx=%0d data=%h expected 1 %0d %h",
                             k, rf_write_enable, rf_write_idx, rf_write_data, k - 1, 32'h100 + 32'(k - 1));
                end
            end
            if (k == 10) begin
                checks++;
                if ({rf_write_enable, busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_idle: en=%b busy=%b expected 0 0", rf_write_enable, busy);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fixed_priority();
        test_x0_discard();
        test_starvation();
        test_reset_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
